// File: rtl/run_detect_if.sv
// Handshake bundle for the run-length detector: sample controls in, run status out.
// Widths follow the same RUN_LEN / CNT_W parameters as the detector that uses it.
interface run_detect_if #(
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 8
) ();
  localparam int RW = $clog2(RUN_LEN + 1);
  localparam int SW = $clog2(2 * RUN_LEN + 1);

  logic          en;
  logic          w;
  logic          clr;
  logic          mealy;
  logic          z;
  logic          last_bit;
  logic [RW-1:0] run_len;
  logic [CNT_W-1:0] hit_cnt;
  logic [SW-1:0] state_code;

  modport master (
    output en, w, clr, mealy,
    input  z, last_bit, run_len, hit_cnt, state_code
  );

  modport slave (
    input  en, w, clr, mealy,
    output z, last_bit, run_len, hit_cnt, state_code
  );
endinterface

// File: rtl/run_detect_fsm.sv
// Run-length detector: flags when RUN_LEN identical qualified samples of either
// polarity have been seen, with Moore/Mealy output select and a saturating hit counter.
module run_detect_fsm #(
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  run_detect_if.slave bus
);
  localparam int RW = $clog2(RUN_LEN + 1);
  localparam int SW = $clog2(2 * RUN_LEN + 1);
  localparam logic [RW-1:0]    RUN_MAX = RW'(RUN_LEN);
  localparam logic [RW-1:0]    RUN_ONE = RW'(1);
  localparam logic [SW-1:0]    ONE_OFS = SW'(RUN_LEN);
  localparam logic [CNT_W-1:0] HIT_MAX = '1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state_reg, state_next;
  logic [RW-1:0]    run_reg, run_next;
  logic             last_reg, last_next;
  logic [CNT_W-1:0] hit_reg, hit_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      run_reg   <= '0;
      last_reg  <= 1'b0;
      hit_reg   <= '0;
    end else begin
      state_reg <= state_next;
      run_reg   <= run_next;
      last_reg  <= last_next;
      hit_reg   <= hit_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    run_next   = run_reg;
    last_next  = last_reg;
    hit_next   = hit_reg;

    if (bus.clr) begin
      state_next = S_IDLE;
      run_next   = '0;
      last_next  = 1'b0;
      hit_next   = '0;
    end else if (bus.en) begin
      case (state_reg)
        S_IDLE: begin
          state_next = S_RUN;
          run_next   = RUN_ONE;
          last_next  = bus.w;
        end
        S_RUN: begin
          if (bus.w == last_reg) begin
            if (run_reg != RUN_MAX) run_next = run_reg + 1'b1;
          end else begin
            // a polarity change restarts at length 1, never back to idle
            run_next  = RUN_ONE;
            last_next = bus.w;
          end
        end
        default: state_next = S_IDLE;
      endcase

      // count only the edge that first reaches the threshold
      if (run_reg != RUN_MAX && run_next == RUN_MAX && hit_reg != HIT_MAX)
        hit_next = hit_reg + 1'b1;
    end
  end

  // run_next is already zero under clr and equals run_reg without en; gating keeps
  // the Mealy flag tied to an actually presented sample.
  assign bus.z = bus.mealy ? (bus.en & ~bus.clr & (run_next == RUN_MAX))
                           : (run_reg == RUN_MAX);

  assign bus.run_len    = run_reg;
  assign bus.last_bit   = last_reg;
  assign bus.hit_cnt    = hit_reg;
  assign bus.state_code = (state_reg == S_IDLE) ? '0
                        : (SW'(run_reg) + (last_reg ? ONE_OFS : '0));
endmodule

// File: tb/tb_run_detect_fsm.sv
// Self-checking bench: table vectors scored through a cycle-tagged queue, plus
// hand sequences for Mealy timing, RUN_LEN=2, and asynchronous reset.
module tb_run_detect_fsm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, w = 1'b0, clr = 1'b0, mealy = 1'b0;

  always #5 clk = ~clk;

  run_detect_if #(.RUN_LEN(4), .CNT_W(2)) bus_a ();
  run_detect_if #(.RUN_LEN(2), .CNT_W(8)) bus_b ();

  assign bus_a.en = en;  assign bus_a.w = w;  assign bus_a.clr = clr;  assign bus_a.mealy = mealy;
  assign bus_b.en = en;  assign bus_b.w = w;  assign bus_b.clr = clr;  assign bus_b.mealy = mealy;

  run_detect_fsm #(.RUN_LEN(4), .CNT_W(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  run_detect_fsm #(.RUN_LEN(2), .CNT_W(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  typedef struct {
    logic       en;
    logic       w;
    logic       clr;
    logic [3:0] sc;
    logic       z;
    logic [1:0] hit;
  } vec_t;

  typedef struct {
    int         cyc;
    int         idx;
    logic [3:0] sc;
    logic       z;
    logic [1:0] hit;
  } exp_t;

  exp_t sb[$];
  int   cyc_cnt = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   vec_idx = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic vec_t mk(logic e, logic ww, logic c, logic [3:0] sc, logic z, logic [1:0] hit);
    vec_t v;
    v.en = e; v.w = ww; v.clr = c; v.sc = sc; v.z = z; v.hit = hit;
    return v;
  endfunction

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // scoreboard: pop every expectation targeted at the edge that just happened
  always @(posedge clk) begin
    #2;
    while (sb.size() > 0 && sb[0].cyc == cyc_cnt) begin
      exp_t e;
      e = sb.pop_front();
      chk($sformatf("vec%0d state_code", e.idx), int'(bus_a.state_code), int'(e.sc));
      chk($sformatf("vec%0d z", e.idx), int'(bus_a.z), int'(e.z));
      chk($sformatf("vec%0d hit_cnt", e.idx), int'(bus_a.hit_cnt), int'(e.hit));
    end
  end

  task automatic apply(input vec_t v);
    exp_t e;
    en = v.en; w = v.w; clr = v.clr; mealy = 1'b0;
    e.cyc = cyc_cnt + 1; e.idx = vec_idx; e.sc = v.sc; e.z = v.z; e.hit = v.hit;
    sb.push_back(e);
    vec_idx++;
    @(posedge clk); #1;
  endtask

  task automatic tick(input logic e, input logic ww, input logic c);
    en = e; w = ww; clr = c;
    @(posedge clk); #1;
  endtask

  vec_t tbl [20];

  initial begin
    // four zeros reach the threshold, a fifth stays saturated
    tbl[0]  = mk(1, 0, 0, 1, 0, 0);
    tbl[1]  = mk(1, 0, 0, 2, 0, 0);
    tbl[2]  = mk(1, 0, 0, 3, 0, 0);
    tbl[3]  = mk(1, 0, 0, 4, 1, 1);
    tbl[4]  = mk(1, 0, 0, 4, 1, 1);
    // switch to ones, reach 8, then a zero restarts at 1
    tbl[5]  = mk(1, 1, 0, 5, 0, 1);
    tbl[6]  = mk(1, 1, 0, 6, 0, 1);
    tbl[7]  = mk(1, 1, 0, 7, 0, 1);
    tbl[8]  = mk(1, 1, 0, 8, 1, 2);
    tbl[9]  = mk(1, 0, 0, 1, 0, 2);
    // clear, two zeros, five gap cycles with toggling w, two more zeros
    tbl[10] = mk(1, 0, 1, 0, 0, 0);
    tbl[11] = mk(1, 0, 0, 1, 0, 0);
    tbl[12] = mk(1, 0, 0, 2, 0, 0);
    tbl[13] = mk(0, 1, 0, 2, 0, 0);
    tbl[14] = mk(0, 0, 0, 2, 0, 0);
    tbl[15] = mk(0, 1, 0, 2, 0, 0);
    tbl[16] = mk(0, 0, 0, 2, 0, 0);
    tbl[17] = mk(0, 1, 0, 2, 0, 0);
    tbl[18] = mk(1, 0, 0, 3, 0, 0);
    tbl[19] = mk(1, 0, 0, 4, 1, 1);

    // reset values while held
    #3;
    chk("rst state_code", int'(bus_a.state_code), 0);
    chk("rst run_len", int'(bus_a.run_len), 0);
    chk("rst last_bit", int'(bus_a.last_bit), 0);
    chk("rst hit_cnt", int'(bus_a.hit_cnt), 0);
    chk("rst z", int'(bus_a.z), 0);
    #19 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 20; i++) apply(tbl[i]);
    chk("sat run_len", int'(bus_a.run_len), 4);
    chk("sat last_bit", int'(bus_a.last_bit), 0);

    // 2-bit hit counter across six alternating 4-runs
    tick(1, 0, 1);
    chk("clr hit_cnt", int'(bus_a.hit_cnt), 0);
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 4; k++) begin
        logic       bit_v;
        logic [3:0] sc_v;
        logic [1:0] hit_v;
        bit_v = (r % 2 == 1);
        sc_v  = 4'((bit_v ? 4 : 0) + k + 1);
        hit_v = (k == 3) ? 2'((r + 1 > 3) ? 3 : r + 1) : 2'((r > 3) ? 3 : r);
        apply(mk(1, bit_v, 0, sc_v, (k == 3), hit_v));
      end
    end
    apply(mk(1, 0, 1, 0, 0, 0));

    // Mealy output is live before the capturing edge
    mealy = 1'b1;
    tick(1, 1, 0); tick(1, 1, 0); tick(1, 1, 0);
    chk("mealy three ones state_code", int'(bus_a.state_code), 7);
    chk("mealy z pre-edge", int'(bus_a.z), 1);
    en = 1'b0; #1;
    chk("mealy z en low", int'(bus_a.z), 0);
    mealy = 1'b0; #1;
    chk("moore z run3", int'(bus_a.z), 0);
    mealy = 1'b1; en = 1'b1; w = 1'b0; #1;
    chk("mealy z mismatch", int'(bus_a.z), 0);
    tick(1, 1, 0);
    chk("mealy edge state_code", int'(bus_a.state_code), 8);
    chk("mealy edge hit_cnt", int'(bus_a.hit_cnt), 1);
    chk("mealy z saturated match", int'(bus_a.z), 1);
    clr = 1'b1; #1;
    chk("mealy z under clr", int'(bus_a.z), 0);
    clr = 1'b0; mealy = 1'b0;

    // RUN_LEN=2: first matching sample after a start hits the threshold
    tick(1, 0, 1);
    tick(1, 0, 0);
    chk("rl2 s1 state_code", int'(bus_b.state_code), 1);
    chk("rl2 s1 z", int'(bus_b.z), 0);
    tick(1, 0, 0);
    chk("rl2 s2 state_code", int'(bus_b.state_code), 2);
    chk("rl2 s2 z", int'(bus_b.z), 1);
    chk("rl2 s2 hit_cnt", int'(bus_b.hit_cnt), 1);
    tick(1, 1, 0);
    chk("rl2 s3 state_code", int'(bus_b.state_code), 3);
    chk("rl2 s3 z", int'(bus_b.z), 0);
    tick(1, 1, 0);
    chk("rl2 s4 state_code", int'(bus_b.state_code), 4);
    chk("rl2 s4 hit_cnt", int'(bus_b.hit_cnt), 2);

    // asynchronous reset mid-run
    tick(1, 0, 1);
    tick(1, 1, 0); tick(1, 1, 0); tick(1, 1, 0);
    chk("pre-rst state_code", int'(bus_a.state_code), 7);
    #2 rst_n = 1'b0; mealy = 1'b1; en = 1'b1; w = 1'b1;
    #1;
    chk("async state_code", int'(bus_a.state_code), 0);
    chk("async run_len", int'(bus_a.run_len), 0);
    chk("async last_bit", int'(bus_a.last_bit), 0);
    chk("async hit_cnt", int'(bus_a.hit_cnt), 0);
    chk("async mealy z", int'(bus_a.z), 0);
    #2 rst_n = 1'b1; mealy = 1'b0;
    @(posedge clk); #1;
    chk("post-rst state_code", int'(bus_a.state_code), 5);
    chk("post-rst last_bit", int'(bus_a.last_bit), 1);
    chk("post-rst run_len", int'(bus_a.run_len), 1);

    tick(0, 0, 0);
    tick(0, 0, 0);
    chk("scoreboard drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
